// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// Parametrised VGA raster timing generator with registered, zero-skew outputs.
// Rev    : 1.0
// ============================================================================
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CLK_DIV   = 1,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          restart,
   output logic          pixel_tick,
   output logic [HW-1:0] hpos,
   output logic [VW-1:0] vpos,
   output logic          hsync,
   output logic          vsync,
   output logic          display_on,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_count
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   generate
      if (H_TOTAL > (2 ** HW)) begin : g_bad_htotal
         $error("vga_timing_gen: H_TOTAL does not fit in hpos");
      end
      if (V_TOTAL > (2 ** VW)) begin : g_bad_vtotal
         $error("vga_timing_gen: V_TOTAL does not fit in vpos");
      end
      if (CLK_DIV < 1) begin : g_bad_clkdiv
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
   endgenerate

   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] hpos_q, hpos_d;
   logic [VW-1:0] vpos_q, vpos_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          disp_q, disp_d;
   logic          line_q, line_d;
   logic          frame_q, frame_d;
   logic [7:0]    fcnt_q, fcnt_d;
   logic          armed_q, armed_d;
   logic          tick;

   assign tick = en & (div_q == DIV_LAST);

   always_comb begin
      div_d   = div_q;
      hpos_d  = hpos_q;
      vpos_d  = vpos_q;
      fcnt_d  = fcnt_q;
      armed_d = armed_q;
      line_d  = 1'b0;
      frame_d = 1'b0;

      if (restart) begin
         div_d   = '0;
         hpos_d  = H_LAST;
         vpos_d  = V_LAST;
         armed_d = 1'b0;
      end else if (en) begin
         div_d = tick ? '0 : div_q + DW'(1);
         if (tick) begin
            // armed_q separates a real end-of-frame wrap from leaving the idle position
            armed_d = 1'b1;
            if (hpos_q == H_LAST) begin
               hpos_d = '0;
               line_d = 1'b1;
               if (vpos_q == V_LAST) begin
                  vpos_d  = '0;
                  frame_d = 1'b1;
                  if (armed_q) begin
                     fcnt_d = fcnt_q + 8'd1;
                  end
               end else begin
                  vpos_d = vpos_q + VW'(1);
               end
            end else begin
               hpos_d = hpos_q + HW'(1);
            end
         end
      end

      // Decode from the next position so every output lines up with hpos/vpos.
      hsync_d = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
      disp_d  = (hpos_d <= H_ACT_LAST) && (vpos_d <= V_ACT_LAST);
      if (restart) begin
         hsync_d = ~HSYNC_POL;
         vsync_d = ~VSYNC_POL;
         disp_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         hpos_q  <= H_LAST;
         vpos_q  <= V_LAST;
         hsync_q <= ~HSYNC_POL;
         vsync_q <= ~VSYNC_POL;
         disp_q  <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         fcnt_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         disp_q  <= disp_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         fcnt_q  <= fcnt_d;
         armed_q <= armed_d;
      end
   end

   assign pixel_tick  = tick;
   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = disp_q;
   assign line_start  = line_q;
   assign frame_start = frame_q;
   assign frame_count = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_gen
// Bench for vga_timing_gen: default 640x480 instance plus a small divided one.
// Rev    : 1.0
// ============================================================================
module tb_vga_timing_gen;

   // Small configuration (instance B)
   localparam int B_HA = 8, B_HFP = 2, B_HS = 2, B_HBP = 2;
   localparam int B_VA = 4, B_VFP = 1, B_VS = 1, B_VBP = 1;
   localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
   localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
   localparam int B_N  = B_HT * B_VT;
   localparam int B_CD = 2;

   logic clk, rst;
   logic en_a, restart_a, en_b, restart_b;

   logic       pt_a, hs_a, vs_a, disp_a, ls_a, fs_a;
   logic [9:0] hpos_a, vpos_a;
   logic [7:0] fc_a;
   logic       pt_b, hs_b, vs_b, disp_b, ls_b, fs_b;
   logic [3:0] hpos_b;
   logic [2:0] vpos_b;
   logic [7:0] fc_b;

   logic [32:0] a_out;
   logic [19:0] b_out;
   assign a_out = {hpos_a, vpos_a, hs_a, vs_a, disp_a, ls_a, fs_a, fc_a};
   assign b_out = {hpos_b, vpos_b, hs_b, vs_b, disp_b, ls_b, fs_b, fc_b};

   vga_timing_gen u_dut_a (
      .clk(clk), .rst(rst), .en(en_a), .restart(restart_a),
      .pixel_tick(pt_a), .hpos(hpos_a), .vpos(vpos_a),
      .hsync(hs_a), .vsync(vs_a), .display_on(disp_a),
      .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(B_CD)
   ) u_dut_b (
      .clk(clk), .rst(rst), .en(en_b), .restart(restart_b),
      .pixel_tick(pt_b), .hpos(hpos_b), .vpos(vpos_b),
      .hsync(hs_b), .vsync(vs_b), .display_on(disp_b),
      .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks, n_pass;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: position kept as a linear pixel index, -1 = idle
   int m_div, m_p, m_fc;
   logic m_ls, m_fs;

   task automatic m_reset();
      m_div = 0; m_p = -1; m_fc = 0; m_ls = 1'b0; m_fs = 1'b0;
   endtask

   task automatic m_step(input logic e, input logic r);
      m_ls = 1'b0; m_fs = 1'b0;
      if (r) begin
         m_div = 0; m_p = -1;
      end else if (e) begin
         if (m_div == B_CD - 1) begin
            m_div = 0;
            if (m_p == B_N - 1) m_fc = (m_fc + 1) % 256;
            m_p  = (m_p + 1) % B_N;
            m_ls = (m_p % B_HT == 0);
            m_fs = (m_p == 0);
         end else begin
            m_div++;
         end
      end
   endtask

   function automatic logic [19:0] m_exp();
      int h, v;
      logic hs, vs, d;
      h  = (m_p < 0) ? B_HT - 1 : m_p % B_HT;
      v  = (m_p < 0) ? B_VT - 1 : m_p / B_HT;
      hs = (h >= B_HA + B_HFP) && (h < B_HA + B_HFP + B_HS);
      vs = !((v >= B_VA + B_VFP) && (v < B_VA + B_VFP + B_VS));
      d  = (h < B_HA) && (v < B_VA);
      return {4'(h), 3'(v), hs, vs, d, m_ls, m_fs, 8'(m_fc)};
   endfunction

   // Called at posedge+1; returns at the following posedge+1.
   task automatic b_cycle(input logic e, input logic r);
      en_b = e; restart_b = r;
      #1;
      chk("b_pixel_tick", pt_b, e && (m_div == B_CD - 1));
      @(posedge clk);
      m_step(e, r);
      #1;
      chk("b_outputs", b_out, m_exp());
   endtask

   typedef struct {
      logic en; logic rs; int h; int v; logic hs; logic d; logic ls; logic fs;
   } vec_t;
   vec_t va[9];

   int cyc, last_ls, period, hs_low, hs_bad, vs_bad, d_bad, strobe_cnt;
   int fs_cnt, disp_cnt, disp_bad, wrap_seen, prev_fc, pre_wrap;
   logic reached;
   logic [19:0] snap;
   logic [7:0] fc_snap;
   int lsq[$];

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_pass = 0;
      va[0] = '{1'b1, 1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
      va[1] = '{1'b1, 1'b0,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      va[2] = '{1'b0, 1'b0,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      va[3] = '{1'b0, 1'b0,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      va[4] = '{1'b1, 1'b0,   2,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      va[5] = '{1'b1, 1'b1, 799, 524, 1'b1, 1'b0, 1'b0, 1'b0};
      va[6] = '{1'b0, 1'b1, 799, 524, 1'b1, 1'b0, 1'b0, 1'b0};
      va[7] = '{1'b1, 1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
      va[8] = '{1'b1, 1'b0,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; en_a = 1'b1; restart_a = 1'b0; en_b = 1'b0; restart_b = 1'b0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("a_reset", a_out, {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
      chk("b_reset", b_out, m_exp());
      chk("b_reset_tick", pt_b, 1'b0);
      rst = 1'b0;

      // Instance A: vector table from reset release
      for (int i = 0; i < 9; i++) begin
         en_a = va[i].en; restart_a = va[i].rs;
         @(posedge clk); #1;
         chk($sformatf("a_vec%0d", i), a_out,
             {10'(va[i].h), 10'(va[i].v), va[i].hs, 1'b1, va[i].d, va[i].ls, va[i].fs, 8'd0});
      end

      // Instance A: scan lines 0..2 up to (300,2)
      en_a = 1'b1; restart_a = 1'b0;
      cyc = 0; last_ls = -1; period = -1; hs_low = 0; hs_bad = 0; vs_bad = 0; d_bad = 0;
      reached = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1; cyc++;
         if (ls_a) begin
            if (last_ls >= 0 && period < 0) period = cyc - last_ls;
            last_ls = cyc;
         end
         if (vpos_a == 10'd1 && !hs_a) hs_low++;
         if (hs_a !== !(hpos_a >= 10'd656 && hpos_a <= 10'd751)) hs_bad++;
         if (vs_a !== 1'b1) vs_bad++;
         if (disp_a !== (hpos_a < 10'd640 && vpos_a < 10'd480)) d_bad++;
         if (hpos_a == 10'd300 && vpos_a == 10'd2) begin
            reached = 1'b1;
            break;
         end
      end
      chk("a_reach_300_2", reached, 1'b1);
      chk("a_line_period", period, 800);
      chk("a_hsync_low_clks", hs_low, 96);
      chk("a_hsync_window", hs_bad, 0);
      chk("a_vsync_idle", vs_bad, 0);
      chk("a_display_window", d_bad, 0);

      // Asynchronous reset mid-line, observed before the next edge
      #2; rst = 1'b1; #1;
      chk("a_async_reset", a_out, {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
      m_reset();
      en_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Instance B: line period and hsync window
      for (int i = 0; i < 70; i++) begin
         b_cycle(1'b1, 1'b0);
         if (ls_b) lsq.push_back(i);
         if (vpos_b == 3'd1 && hs_b) hs_low++;
      end
      chk("b_line_period", (lsq.size() >= 3) ? lsq[2] - lsq[1] : -1, 28);
      chk("b_hsync_hi_clks", hs_low - 96, 4);

      // Freeze with en low
      snap = b_out; strobe_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         b_cycle(1'b0, 1'b0);
         strobe_cnt += int'(ls_b | fs_b);
      end
      chk("b_freeze_state", b_out, snap);
      chk("b_freeze_strobes", strobe_cnt, 0);

      // Restart at (9,2) of the second frame, then restart with en low
      reached = 1'b0;
      for (int i = 0; i < 600; i++) begin
         b_cycle(1'b1, 1'b0);
         if (fc_b == 8'd1 && hpos_b == 4'd9 && vpos_b == 3'd2) begin
            reached = 1'b1;
            break;
         end
      end
      chk("b_reach_9_2", reached, 1'b1);
      fc_snap = fc_b;
      b_cycle(1'b1, 1'b1);
      chk("b_restart_idle", {hpos_b, vpos_b, disp_b, fc_b}, {4'd13, 3'd6, 1'b0, fc_snap});
      b_cycle(1'b0, 1'b1);
      chk("b_restart_en_low", {hpos_b, vpos_b, disp_b, fc_b}, {4'd13, 3'd6, 1'b0, fc_snap});
      b_cycle(1'b1, 1'b0);
      b_cycle(1'b1, 1'b0);
      chk("b_restart_first", {hpos_b, vpos_b, ls_b, fs_b, fc_b}, {4'd0, 3'd0, 1'b1, 1'b1, fc_snap});

      // Randomised en/restart against the model
      for (int i = 0; i < 3000; i++)
         b_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);

      // Reset, then 256 completed frames: frame_count wraps 255 -> 0
      en_b = 1'b1;
      #2; rst = 1'b1; #1;
      m_reset();
      chk("b_reset2", b_out, m_exp());
      chk("b_reset2_tick", pt_b, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      fs_cnt = 0; disp_cnt = 0; disp_bad = 0; wrap_seen = 0; prev_fc = 0; pre_wrap = -1;
      for (int i = 0; i < 256 * 196 + 400; i++) begin
         b_cycle(1'b1, 1'b0);
         if (fs_b) begin
            if (fs_cnt > 0 && disp_cnt != 2 * B_HA * B_VA) disp_bad++;
            fs_cnt++;
            disp_cnt = 0;
         end
         if (disp_b) disp_cnt++;
         if (int'(fc_b) != prev_fc) begin
            if (prev_fc == 255 && fc_b == 8'd0) wrap_seen++;
            pre_wrap = prev_fc;
            prev_fc  = int'(fc_b);
         end
         if (fs_cnt == 257) break;
      end
      chk("b_frames_seen", fs_cnt, 257);
      chk("b_fc_wrapped", fc_b, 8'd0);
      chk("b_fc_pre_wrap", pre_wrap, 255);
      chk("b_wrap_once", wrap_seen, 1);
      chk("b_display_per_frame", disp_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
